// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ALU select codes, ALU-op codes and control-bundle field indices
package riscv_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_R   = 2'b10,
    OP_I   = 2'b11
  } alu_op_t;
  // id_ctrl / ex_ctrl = {reg_write, mem_read, mem_write, mem_to_reg, branch}
  localparam int CTRL_BRANCH     = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_REG_WRITE  = 4;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: one ALU operand's EX/MEM then MEM/WB forwarding select; x0 never forwarded
module fwd_mux #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic [RADDR-1:0] rs,
  input  logic [XLEN-1:0]  reg_data,
  input  logic             exmem_reg_write,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic [XLEN-1:0]  memwb_result,
  output logic [XLEN-1:0]  data
);
  logic nz;
  always_comb begin
    nz = rs != '0;
    data = (nz && exmem_reg_write && exmem_rd == rs) ? exmem_result :
           (nz && memwb_reg_write && memwb_rd == rs) ? memwb_result : reg_data;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register, operand forwarding, ALU-select decode and load-use detect.
// Define IDEX_FWD_EN to enable EX/MEM and MEM/WB forwarding (off by default).
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RADDR-1:0] id_rs1,
  input  logic [RADDR-1:0] id_rs2,
  input  logic [RADDR-1:0] id_rd,
  input  logic [1:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7_5,
  input  logic [4:0]       id_ctrl,
  input  logic             stall,
  input  logic             flush,
  input  logic             exmem_reg_write,
  input  logic             memwb_reg_write,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic [XLEN-1:0]  memwb_result,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_sel,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [RADDR-1:0] ex_rd,
  output logic [4:0]       ex_ctrl,
  output logic [XLEN-1:0]  ex_rs2_fwd,
  output logic             load_use_hazard
);
  logic [XLEN-1:0]  ex_rs1_data, ex_rs2_data, ex_imm, rs1_fwd, rs2_fwd;
  logic [RADDR-1:0] ex_rs1, ex_rs2;
  alu_op_t          ex_alu_op;
  logic             ex_alu_src, ex_funct7_5, raw;
  logic [2:0]       ex_funct3;

  function automatic logic [3:0] alu_decode(alu_op_t op, logic [2:0] f3, logic f7_5);
    return op == OP_ADD ? ALU_ADD :
           op == OP_SUB ? ALU_SUB :
           f3 == 3'b111 ? ALU_AND :
           f3 == 3'b110 ? ALU_OR  :
           (op == OP_R && f3 == 3'b000 && f7_5) ? ALU_SUB : ALU_ADD;
  endfunction

  // reset and bubble are the same all-zero state
  always_ff @(posedge clk)
    if (rst || flush) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_alu_op   <= OP_ADD;
      ex_alu_src  <= 1'b0;
      ex_funct3   <= '0;
      ex_funct7_5 <= 1'b0;
      ex_ctrl     <= '0;
    end else if (!stall) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_alu_op   <= alu_op_t'(id_alu_op);
      ex_alu_src  <= id_alu_src;
      ex_funct3   <= id_funct3;
      ex_funct7_5 <= id_funct7_5;
      ex_ctrl     <= id_ctrl;
    end

`ifdef IDEX_FWD_EN
  fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_a (
    .rs(ex_rs1), .reg_data(ex_rs1_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .data(rs1_fwd)
  );
  fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_b (
    .rs(ex_rs2), .reg_data(ex_rs2_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .data(rs2_fwd)
  );
  assign load_use_hazard = raw && ex_ctrl[CTRL_MEM_READ];
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result, ex_rs1, ex_rs2};
  assign rs1_fwd = ex_rs1_data;
  assign rs2_fwd = ex_rs2_data;
  // without forwarding every RAW on a live EX result must stall, not just loads
  assign load_use_hazard = raw;
`endif

  always_comb begin
    raw        = ex_valid && id_valid && ex_rd != '0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    alu_a      = rs1_fwd;
    alu_b      = ex_alu_src ? ex_imm : rs2_fwd;
    ex_rs2_fwd = rs2_fwd;
    alu_sel    = alu_decode(ex_alu_op, ex_funct3, ex_funct7_5);
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with hand-computed expectations for id_ex_stage,
// covering both the forwarding and non-forwarding (IDEX_FWD_EN) builds.
module tb_id_ex_stage;
`ifdef IDEX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic        clk = 1'b0, rst;
  logic        id_valid, id_alu_src, id_funct7_5, stall, flush;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_ctrl;
  logic [1:0]  id_alu_op;
  logic [2:0]  id_funct3;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_pc, ex_rs2_fwd;
  logic [3:0]  alu_sel;
  logic        ex_valid, load_use_hazard;
  logic [4:0]  ex_rd, ex_ctrl;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
    .id_ctrl(id_ctrl), .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_rs2_fwd(ex_rs2_fwd),
    .load_use_hazard(load_use_hazard)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fwd(input logic ew, input logic [4:0] erd, input logic [31:0] er,
                     input logic mw, input logic [4:0] mrd, input logic [31:0] mr);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = er;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mr;
    #1;
  endtask

  task automatic op(input logic [1:0] o, input logic [2:0] f3, input logic f7);
    id_alu_op = o; id_funct3 = f3; id_funct7_5 = f7;
    tick();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b1; id_pc = 32'h40; id_rs1_data = 32'h9; id_rs2_data = 32'h9;
    id_imm = 32'h0; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd1; id_ctrl = 5'b11000;
    id_alu_op = 2'b01; id_alu_src = 1'b0; id_funct3 = 3'b0; id_funct7_5 = 1'b0;
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    check("rst_valid", {31'b0, ex_valid}, 32'h0);
    check("rst_sel", {28'b0, alu_sel}, 32'h2);
    check("rst_a", alu_a, 32'h0);
    check("rst_b", alu_b, 32'h0);
    check("rst_haz", {31'b0, load_use_hazard}, 32'h0);
    check("rst_ctrl", {27'b0, ex_ctrl}, 32'h0);

    rst = 1'b0;
    id_pc = 32'h100; id_rs1_data = 32'd5; id_rs2_data = 32'd7;
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3; id_ctrl = 5'b10000;
    op(2'b10, 3'b000, 1'b0);
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd7);
    check("add_sel", {28'b0, alu_sel}, 32'h2);
    check("add_valid", {31'b0, ex_valid}, 32'h1);
    check("add_pc", ex_pc, 32'h100);
    check("add_rd", {27'b0, ex_rd}, 32'd3);

    op(2'b01, 3'b000, 1'b0); check("sel_sub", {28'b0, alu_sel}, 32'h6);
    op(2'b10, 3'b000, 1'b1); check("sel_rsub", {28'b0, alu_sel}, 32'h6);
    op(2'b11, 3'b000, 1'b1); check("sel_iadd", {28'b0, alu_sel}, 32'h2);
    op(2'b10, 3'b111, 1'b0); check("sel_rand", {28'b0, alu_sel}, 32'h0);
    op(2'b11, 3'b110, 1'b0); check("sel_ior", {28'b0, alu_sel}, 32'h1);
    op(2'b10, 3'b100, 1'b0); check("sel_other", {28'b0, alu_sel}, 32'h2);
    op(2'b11, 3'b111, 1'b1); check("sel_iand", {28'b0, alu_sel}, 32'h0);

    id_rs1 = 5'd3; id_rs1_data = 32'h11; id_alu_op = 2'b00;
    tick();
    fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    check("fwd_exmem", alu_a, FWD ? 32'hAA : 32'h11);
    fwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    check("fwd_memwb", alu_a, FWD ? 32'hBB : 32'h11);
    fwd(1'b0, 5'd3, 32'hAA, 1'b0, 5'd3, 32'hBB);
    check("fwd_none", alu_a, 32'h11);
    id_rs1 = 5'd0; id_rs1_data = 32'h22;
    tick();
    fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    check("fwd_x0", alu_a, 32'h22);

    id_rs2 = 5'd5; id_rs2_data = 32'h33; id_alu_src = 1'b1; id_imm = 32'hFFFF_FFFC;
    tick();
    fwd(1'b1, 5'd5, 32'h44, 1'b0, 5'd0, 32'h0);
    check("imm_b", alu_b, 32'hFFFF_FFFC);
    check("imm_st", ex_rs2_fwd, FWD ? 32'h44 : 32'h33);
    id_alu_src = 1'b0;
    tick();
    check("reg_b", alu_b, FWD ? 32'h44 : 32'h33);
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    id_ctrl = 5'b11010; id_rd = 5'd4; id_valid = 1'b1;
    tick();
    id_rs1 = 5'd1; id_rs2 = 5'd4; #1;
    check("lu_hit", {31'b0, load_use_hazard}, 32'h1);
    id_valid = 1'b0; #1;
    check("lu_idinv", {31'b0, load_use_hazard}, 32'h0);
    id_valid = 1'b1; id_rs1 = 5'd4; id_rs2 = 5'd6; #1;
    check("lu_rs1", {31'b0, load_use_hazard}, 32'h1);
    id_ctrl = 5'b10000;
    tick();
    check("raw_alu", {31'b0, load_use_hazard}, FWD ? 32'h0 : 32'h1);
    id_ctrl = 5'b11010; id_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    tick();
    check("lu_x0", {31'b0, load_use_hazard}, 32'h0);

    id_pc = 32'h200; id_rd = 5'd7; id_rs1 = 5'd9; id_rs1_data = 32'h55;
    id_ctrl = 5'b10000; id_alu_op = 2'b10; id_funct3 = 3'b111; id_funct7_5 = 1'b0;
    tick();
    stall = 1'b1;
    id_pc = 32'h300; id_rd = 5'd8; id_rs1_data = 32'h66; id_alu_op = 2'b01; id_ctrl = 5'b00001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", ex_pc, 32'h200);
      check("stall_a", alu_a, 32'h55);
    end
    check("stall_rd", {27'b0, ex_rd}, 32'd7);
    check("stall_sel", {28'b0, alu_sel}, 32'h0);
    flush = 1'b1;
    tick();
    check("sf_valid", {31'b0, ex_valid}, 32'h0);
    check("sf_ctrl", {27'b0, ex_ctrl}, 32'h0);
    check("sf_pc", ex_pc, 32'h0);
    stall = 1'b0; flush = 1'b0;
    tick();
    check("resume_pc", ex_pc, 32'h300);
    check("resume_ctrl", {27'b0, ex_ctrl}, 32'h1);
    stall = 1'b1; rst = 1'b1;
    tick();
    check("rs_valid", {31'b0, ex_valid}, 32'h0);
    check("rs_a", alu_a, 32'h0);
    check("rs_sel", {28'b0, alu_sel}, 32'h2);
    check("rs_pc", ex_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
